// File: rtl/riscv_membuf_q.sv
// Parametrised memory-request queue between the CPU memory interface and the MMU/PMA/PMP/cache pipeline.
// Circular buffer with optional same-cycle fall-through when empty, flush, stall and sticky overflow.
package riscv_membuf_pkg;
    typedef logic [2:0] biu_size_t;
    typedef logic [2:0] biu_prot_t;
endpackage

module riscv_membuf_q
    import riscv_membuf_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 4,
    parameter int FALLTHROUGH = 0,
    parameter int AFULL_LVL   = DEPTH - 1
)(
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         stall_i,
    input  logic                         req_i,
    input  logic [XLEN-1:0]              adr_i,
    input  biu_size_t                    size_i,
    input  logic                         lock_i,
    input  biu_prot_t                    prot_i,
    input  logic                         we_i,
    input  logic [XLEN-1:0]              d_i,
    output logic                         req_o,
    input  logic                         ack_i,
    output logic [XLEN-1:0]              adr_o,
    output biu_size_t                    size_o,
    output logic                         lock_o,
    output biu_prot_t                    prot_o,
    output logic                         we_o,
    output logic [XLEN-1:0]              q_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic                         almost_full_o,
    output logic                         overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [XLEN-1:0] adr;
        biu_size_t       size;
        logic            lock;
        biu_prot_t       prot;
        logic            we;
        logic [XLEN-1:0] d;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_rd_ptr, r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic            r_ovf;

    entry_t          w_in, w_head;
    logic            w_empty, w_full, w_bypass;
    logic            w_pop, w_push, w_store, w_deq;

    assign w_in    = '{adr: adr_i, size: size_i, lock: lock_i, prot: prot_i, we: we_i, d: d_i};
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    // Bypass path is gated by reset so outputs stay at their reset values while rst_ni is low.
    assign w_bypass = (FALLTHROUGH != 0) && w_empty && rst_ni;

    assign req_o  = ~flush_i & (w_bypass ? req_i : ~w_empty);
    assign w_head = w_bypass ? w_in : (w_empty ? '0 : r_mem[r_rd_ptr]);

    assign w_pop  = ack_i & req_o & ~stall_i;
    assign w_push = req_i & ~flush_i & (~w_full | w_pop);
    // A bypassed request that is accepted in the same cycle never touches storage.
    assign w_store = w_push & ~(w_bypass & w_pop);
    assign w_deq   = w_pop & ~w_bypass;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_store) begin
                r_mem[r_wr_ptr] <= w_in;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_deq) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_store & ~w_deq)      r_count <= r_count + CW'(1);
            else if (w_deq & ~w_store) r_count <= r_count - CW'(1);
            if (req_i & w_full & ~w_pop) r_ovf <= 1'b1;
        end
    end

    assign adr_o         = w_head.adr;
    assign size_o        = w_head.size;
    assign lock_o        = w_head.lock;
    assign prot_o        = w_head.prot;
    assign we_o          = w_head.we;
    assign q_o           = w_head.d;
    assign count_o       = r_count;
    assign empty_o       = w_empty;
    assign full_o        = w_full;
    assign almost_full_o = (int'(r_count) >= AFULL_LVL);
    assign overflow_o    = r_ovf;
endmodule

// File: tb/tb_riscv_membuf_q.sv
// Bench for riscv_membuf_q: drives a FALLTHROUGH=0 and a FALLTHROUGH=1 instance with shared inputs
// and compares both against queue-based reference models, plus directed vectors and sequences.
module tb_riscv_membuf_q;
    import riscv_membuf_pkg::*;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] adr;
        logic [2:0]  size;
        logic        lock;
        logic [2:0]  prot;
        logic        we;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        logic        req;
        logic [31:0] adr;
        logic        ack;
        logic        flush;
        logic        chkd;
        logic        er0;
        logic [31:0] ea0;
        int          ec0;
        logic        er1;
        logic [31:0] ea1;
        int          ec1;
    } vec_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        flush = 1'b0, stall = 1'b0, req = 1'b0, ack = 1'b0, lock = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, d = '0;
    biu_size_t   size = '0;
    biu_prot_t   prot = '0;

    logic        o_req [2];
    logic [31:0] o_adr [2];
    logic [31:0] o_q   [2];
    biu_size_t   o_size[2];
    biu_prot_t   o_prot[2];
    logic        o_lock[2], o_we[2];
    logic [2:0]  o_cnt [2];
    logic        o_empty[2], o_full[2], o_afull[2], o_ovf[2];

    int   n_chk = 0, n_err = 0;
    ent_t mq [2][$];
    bit   movf [2];
    vec_t tbl [12];

    always #5 clk = ~clk;

    riscv_membuf_q #(.XLEN(32), .DEPTH(DEPTH), .FALLTHROUGH(0)) u_ft0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .stall_i(stall), .req_i(req),
        .adr_i(adr), .size_i(size), .lock_i(lock), .prot_i(prot), .we_i(we), .d_i(d),
        .req_o(o_req[0]), .ack_i(ack), .adr_o(o_adr[0]), .size_o(o_size[0]), .lock_o(o_lock[0]),
        .prot_o(o_prot[0]), .we_o(o_we[0]), .q_o(o_q[0]), .count_o(o_cnt[0]), .empty_o(o_empty[0]),
        .full_o(o_full[0]), .almost_full_o(o_afull[0]), .overflow_o(o_ovf[0]));

    riscv_membuf_q #(.XLEN(32), .DEPTH(DEPTH), .FALLTHROUGH(1)) u_ft1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .stall_i(stall), .req_i(req),
        .adr_i(adr), .size_i(size), .lock_i(lock), .prot_i(prot), .we_i(we), .d_i(d),
        .req_o(o_req[1]), .ack_i(ack), .adr_o(o_adr[1]), .size_o(o_size[1]), .lock_o(o_lock[1]),
        .prot_o(o_prot[1]), .we_o(o_we[1]), .q_o(o_q[1]), .count_o(o_cnt[1]), .empty_o(o_empty[1]),
        .full_o(o_full[1]), .almost_full_o(o_afull[1]), .overflow_o(o_ovf[1]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    function automatic ent_t cur_in();
        return {adr, size, lock, prot, we, d};
    endfunction

    task automatic drive(input logic r, input logic [31:0] a, input logic k,
                         input logic s = 1'b0, input logic f = 1'b0);
        req = r; adr = a; ack = k; stall = s; flush = f;
        size = biu_size_t'($urandom_range(0, 7));
        prot = biu_prot_t'($urandom_range(0, 7));
        lock = 1'($urandom_range(0, 1));
        we   = 1'($urandom_range(0, 1));
        d    = $urandom;
    endtask

    task automatic idle_zero();
        req = 0; adr = '0; ack = 0; stall = 0; flush = 0;
        size = '0; prot = '0; lock = 0; we = 0; d = '0;
    endtask

    // Reference: the queue holds stored entries; an empty fall-through queue shows the inputs.
    task automatic model_check();
        for (int m = 0; m < 2; m++) begin
            int   n = mq[m].size();
            logic er;
            ent_t h;
            er = flush ? 1'b0 : (n != 0 ? 1'b1 : (m == 1 ? req : 1'b0));
            h  = (n != 0) ? mq[m][0] : (m == 1 ? cur_in() : ent_t'('0));
            chk($sformatf("req_o[ft%0d]", m),   64'(o_req[m]),   64'(er));
            chk($sformatf("count_o[ft%0d]", m), 64'(o_cnt[m]),   64'(n));
            chk($sformatf("empty_o[ft%0d]", m), 64'(o_empty[m]), 64'(n == 0));
            chk($sformatf("full_o[ft%0d]", m),  64'(o_full[m]),  64'(n == DEPTH));
            chk($sformatf("afull_o[ft%0d]", m), 64'(o_afull[m]), 64'(n >= DEPTH - 1));
            chk($sformatf("ovf_o[ft%0d]", m),   64'(o_ovf[m]),   64'(movf[m]));
            if (!flush) begin
                chk($sformatf("adr_o[ft%0d]", m),  64'(o_adr[m]),  64'(h.adr));
                chk($sformatf("size_o[ft%0d]", m), 64'(o_size[m]), 64'(h.size));
                chk($sformatf("lock_o[ft%0d]", m), 64'(o_lock[m]), 64'(h.lock));
                chk($sformatf("prot_o[ft%0d]", m), 64'(o_prot[m]), 64'(h.prot));
                chk($sformatf("we_o[ft%0d]", m),   64'(o_we[m]),   64'(h.we));
                chk($sformatf("q_o[ft%0d]", m),    64'(o_q[m]),    64'(h.d));
            end
        end
    endtask

    task automatic model_update();
        for (int m = 0; m < 2; m++) begin
            int   n = mq[m].size();
            logic er;
            bit   pop, full;
            er   = flush ? 1'b0 : (n != 0 ? 1'b1 : (m == 1 ? req : 1'b0));
            pop  = ack && er && !stall;
            full = (n == DEPTH);
            if (flush) begin
                mq[m].delete();
                movf[m] = 0;
            end else begin
                if (req && full && !pop) movf[m] = 1;
                if (pop && n != 0) void'(mq[m].pop_front());
                if (req && (!full || pop) && !(n == 0 && pop)) mq[m].push_back(cur_in());
            end
        end
    endtask

    task automatic commit();
        model_check();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        commit();
    endtask

    task automatic chk_reset_state(input string tag);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("%s req_o[ft%0d]", tag, m),   64'(o_req[m]),   64'(0));
            chk($sformatf("%s adr_o[ft%0d]", tag, m),   64'(o_adr[m]),   64'(0));
            chk($sformatf("%s q_o[ft%0d]", tag, m),     64'(o_q[m]),     64'(0));
            chk($sformatf("%s count_o[ft%0d]", tag, m), 64'(o_cnt[m]),   64'(0));
            chk($sformatf("%s empty_o[ft%0d]", tag, m), 64'(o_empty[m]), 64'(1));
            chk($sformatf("%s full_o[ft%0d]", tag, m),  64'(o_full[m]),  64'(0));
            chk($sformatf("%s afull_o[ft%0d]", tag, m), 64'(o_afull[m]), 64'(0));
            chk($sformatf("%s ovf_o[ft%0d]", tag, m),   64'(o_ovf[m]),   64'(0));
        end
    endtask

    function automatic vec_t mkv(logic r, logic [31:0] a, logic k, logic f, logic cd,
                                 logic er0, logic [31:0] ea0, int ec0,
                                 logic er1, logic [31:0] ea1, int ec1);
        vec_t v;
        v.req = r; v.adr = a; v.ack = k; v.flush = f; v.chkd = cd;
        v.er0 = er0; v.ea0 = ea0; v.ec0 = ec0; v.er1 = er1; v.ea1 = ea1; v.ec1 = ec1;
        return v;
    endfunction

    initial begin
        // Outputs sampled at the negedge of the cycle the inputs are applied; count is pre-edge state.
        tbl[0]  = mkv(1, 32'h100, 0, 0, 1,  0, 32'h000, 0,  1, 32'h100, 0);
        tbl[1]  = mkv(1, 32'h104, 0, 0, 1,  1, 32'h100, 1,  1, 32'h100, 1);
        tbl[2]  = mkv(0, 32'h000, 0, 0, 1,  1, 32'h100, 2,  1, 32'h100, 2);
        tbl[3]  = mkv(0, 32'h000, 1, 0, 1,  1, 32'h100, 2,  1, 32'h100, 2);
        tbl[4]  = mkv(0, 32'h000, 0, 0, 1,  1, 32'h104, 1,  1, 32'h104, 1);
        tbl[5]  = mkv(0, 32'h000, 1, 0, 1,  1, 32'h104, 1,  1, 32'h104, 1);
        tbl[6]  = mkv(0, 32'h000, 0, 0, 1,  0, 32'h000, 0,  0, 32'h000, 0);
        tbl[7]  = mkv(1, 32'h040, 1, 0, 1,  0, 32'h000, 0,  1, 32'h040, 0);
        tbl[8]  = mkv(1, 32'h040, 0, 0, 1,  1, 32'h040, 1,  1, 32'h040, 0);
        tbl[9]  = mkv(0, 32'h000, 0, 0, 1,  1, 32'h040, 2,  1, 32'h040, 1);
        tbl[10] = mkv(0, 32'h000, 0, 1, 0,  0, 32'h000, 2,  0, 32'h000, 1);
        tbl[11] = mkv(0, 32'h000, 0, 0, 1,  0, 32'h000, 0,  0, 32'h000, 0);

        idle_zero();
        #12;
        chk_reset_state("por");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            drive(tbl[i].req, tbl[i].adr, tbl[i].ack, 1'b0, tbl[i].flush);
            @(negedge clk);
            chk($sformatf("vec%0d req_o[ft0]", i), 64'(o_req[0]), 64'(tbl[i].er0));
            chk($sformatf("vec%0d count_o[ft0]", i), 64'(o_cnt[0]), 64'(tbl[i].ec0));
            chk($sformatf("vec%0d req_o[ft1]", i), 64'(o_req[1]), 64'(tbl[i].er1));
            chk($sformatf("vec%0d count_o[ft1]", i), 64'(o_cnt[1]), 64'(tbl[i].ec1));
            if (tbl[i].chkd) begin
                chk($sformatf("vec%0d adr_o[ft0]", i), 64'(o_adr[0]), 64'(tbl[i].ea0));
                chk($sformatf("vec%0d adr_o[ft1]", i), 64'(o_adr[1]), 64'(tbl[i].ea1));
            end
            commit();
        end

        // Overflow: fill, push while full, then drain in order.
        for (int i = 0; i < 4; i++) begin drive(1, 32'h10 + 32'(4*i), 0); step(); end
        drive(1, 32'h200, 0); step();
        drive(0, 0, 0);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("ovf count[ft%0d]", m), 64'(o_cnt[m]),  64'(4));
            chk($sformatf("ovf full[ft%0d]", m),  64'(o_full[m]), 64'(1));
            chk($sformatf("ovf flag[ft%0d]", m),  64'(o_ovf[m]),  64'(1));
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1);
            @(negedge clk);
            for (int m = 0; m < 2; m++)
                chk($sformatf("drain%0d adr[ft%0d]", i, m), 64'(o_adr[m]), 64'(32'h10 + 32'(4*i)));
            commit();
        end
        drive(0, 0, 0);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("drained empty[ft%0d]", m), 64'(o_empty[m]), 64'(1));
            chk($sformatf("sticky ovf[ft%0d]", m),    64'(o_ovf[m]),   64'(1));
        end

        // Simultaneous push and pop while full.
        for (int i = 0; i < 4; i++) begin drive(1, 32'h20 + 32'(4*i), 0); step(); end
        drive(1, 32'h300, 1); step();
        drive(0, 0, 0);
        for (int m = 0; m < 2; m++)
            chk($sformatf("full pushpop count[ft%0d]", m), 64'(o_cnt[m]), 64'(4));
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1);
            @(negedge clk);
            for (int m = 0; m < 2; m++)
                chk($sformatf("pp drain%0d adr[ft%0d]", i, m), 64'(o_adr[m]),
                    64'(i == 3 ? 32'h300 : 32'h24 + 32'(4*i)));
            commit();
        end

        // Stall holds the head, then flush with a concurrent request.
        for (int i = 0; i < 3; i++) begin drive(1, 32'h60 + 32'(4*i), 0); step(); end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 1);
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("stall%0d adr[ft%0d]", i, m), 64'(o_adr[m]), 64'(32'h60));
                chk($sformatf("stall%0d cnt[ft%0d]", i, m), 64'(o_cnt[m]), 64'(3));
            end
            commit();
        end
        drive(1, 32'h70, 0, 0, 1); step();
        drive(0, 0, 0);
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("flush cnt[ft%0d]", m), 64'(o_cnt[m]), 64'(0));
            chk($sformatf("flush req[ft%0d]", m), 64'(o_req[m]), 64'(0));
            chk($sformatf("flush ovf[ft%0d]", m), 64'(o_ovf[m]), 64'(0));
        end
        commit();

        // Randomized traffic; wraps the pointers many times.
        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 63) == 0));
            step();
        end

        // Asynchronous reset mid-cycle with two entries held.
        drive(0, 0, 0, 0, 1); step();
        drive(1, 32'h400, 0); step();
        drive(1, 32'h404, 0); step();
        idle_zero();
        for (int m = 0; m < 2; m++)
            chk($sformatf("pre-reset cnt[ft%0d]", m), 64'(o_cnt[m]), 64'(2));
        #2 rst_n = 1'b0;
        #1 chk_reset_state("async");
        for (int m = 0; m < 2; m++) begin mq[m].delete(); movf[m] = 0; end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1, 32'h500, 0); step();
        drive(0, 0, 0);
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("post-reset cnt[ft%0d]", m), 64'(o_cnt[m]), 64'(1));
            chk($sformatf("post-reset adr[ft%0d]", m), 64'(o_adr[m]), 64'(32'h500));
        end
        commit();
        drive(0, 0, 1); step();
        drive(0, 0, 0); step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
